// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial pattern detector with arm/disarm
// sequencing, match counting and an optional match limit.
// Optional idle-gap auto-disarm is enabled by defining SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | disarmed, configuration accepted, waiting for start
// ARMED | sampling qualified bits, emitting match pulses
// DONE  | match limit reached, configuration accepted, start re-arms
module seq_det_ctrl #(
  parameter int               PAT_W       = 6,
  parameter logic [PAT_W-1:0] DEF_PATTERN = 6'b101010,
  parameter int               CNT_W       = 8,
  parameter int               TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             start,
  input  logic             abort,
  input  logic             x_valid,
  input  logic             x,
  output logic             z,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] match_count
);

  localparam int BC_W = $clog2(PAT_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] limit;
  logic [PAT_W-1:0] sr;
  logic [BC_W-1:0]  bit_cnt;

  logic [PAT_W-1:0] sr_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic             limit_hit;
  logic             arm;
  logic             tmo_fire;

  assign busy      = (state == S_ARMED);
  assign done      = (state == S_DONE);
  assign cfg_ready = (state != S_ARMED);

  assign sr_next   = {sr[PAT_W-2:0], x};
  // bit_cnt >= PAT_W-1 is the registered form of "bit_cnt+1 >= PAT_W"
  assign hit       = busy && x_valid && (sr_next == pattern) &&
                     (bit_cnt >= BC_W'(PAT_W - 1));
  assign cnt_inc   = (match_count == '1) ? match_count : match_count + 1'b1;
  assign limit_hit = hit && (limit != '0) && (cnt_inc >= limit);
  // abort outranks start; start is only honoured outside ARMED
  assign arm       = start && !abort && (state != S_ARMED);

`ifdef SEQ_TIMEOUT_EN
  localparam int IC_W = $clog2(TIMEOUT + 1);

  logic [IC_W-1:0] idle_cnt;

  assign tmo_fire = busy && !x_valid && (idle_cnt == IC_W'(TIMEOUT - 1));

  // Idle-gap counter: consecutive unqualified cycles while armed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= tmo_fire && !abort;
      if (arm || !busy || x_valid || tmo_fire) idle_cnt <= '0;
      else                                     idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Configuration latch, shift history, match pulse/count and state sequencing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pattern     <= DEF_PATTERN;
      limit       <= '0;
      sr          <= '0;
      bit_cnt     <= '0;
      match_count <= '0;
      z           <= 1'b0;
    end else begin
      z <= hit;
      if (cfg_valid && cfg_ready) begin
        pattern <= cfg_pattern;
        limit   <= cfg_limit;
      end
      if (arm) begin
        state       <= S_ARMED;
        sr          <= '0;
        bit_cnt     <= '0;
        match_count <= '0;
      end else begin
        case (state)
          S_ARMED: begin
            if (x_valid) begin
              sr <= sr_next;
              if (bit_cnt != BC_W'(PAT_W)) bit_cnt <= bit_cnt + 1'b1;
            end
            if (hit) match_count <= cnt_inc;
            if (abort || tmo_fire) state <= S_IDLE;
            else if (limit_hit)    state <= S_DONE;
          end
          S_DONE: begin
            if (abort) state <= S_IDLE;
          end
          S_IDLE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed testbench for seq_det_ctrl with hand-computed expectations.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_pattern;
  logic [7:0] cfg_limit;
  logic       start;
  logic       abort;
  logic       x_valid;
  logic       x;
  logic       z;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] match_count;

  int n_tests = 0;
  int n_fail  = 0;

  seq_det_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_limit   (cfg_limit),
    .start       (start),
    .abort       (abort),
    .x_valid     (x_valid),
    .x           (x),
    .z           (z),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    x_valid = 1'b1;
    x       = b;
    step();
    x_valid = 1'b0;
    x       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  s1;
    logic [17:0] s2;
    logic [9:0]  s5;

    rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_limit = '0;
    start = 1'b0; abort = 1'b0; x_valid = 1'b0; x = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_z", z, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_count", match_count, 0);
    rst = 1'b1;
    step();

    // default pattern, continuous stream
    start = 1'b1; step(); start = 1'b0;
    chk("t1_busy_armed", busy, 1);
    chk("t1_cfg_ready", cfg_ready, 0);
    s1 = 10'b1010101010;
    for (int k = 0; k < 10; k++) begin
      send(s1[9-k]);
      chk("t1_z", z, (k == 5 || k == 7 || k == 9) ? 1 : 0);
    end
    chk("t1_count", match_count, 3);
    chk("t1_busy", busy, 1);
    chk("t1_done", done, 0);

    // abort beats start in ARMED
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_count", match_count, 3);
    chk("t4_cfg_ready", cfg_ready, 1);
    step();
    chk("t4_still_idle", busy, 0);

    // new pattern with limit, configured in the same cycle as start
    cfg_valid = 1'b1; cfg_pattern = 6'b111000; cfg_limit = 8'd2; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    chk("t2_busy", busy, 1);
    chk("t2_count_clr", match_count, 0);
    s2 = 18'b111000111000111000;
    for (int k = 0; k < 18; k++) begin
      send(s2[17-k]);
      chk("t2_z", z, (k == 5 || k == 11) ? 1 : 0);
      if (k == 11) chk("t2_done_at_limit", done, 1);
    end
    chk("t2_count", match_count, 2);
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);
    chk("t2_cfg_ready", cfg_ready, 1);

    // re-arm from DONE with new config, stream with gaps
    cfg_valid = 1'b1; cfg_pattern = 6'b101010; cfg_limit = 8'd0; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    chk("t3_busy", busy, 1);
    chk("t3_done", done, 0);
    chk("t3_count_clr", match_count, 0);
    send(1'b1); chk("t3_z_b1", z, 0);
    send(1'b0); chk("t3_z_b2", z, 0);
    send(1'b1); chk("t3_z_b3", z, 0);
    for (int k = 0; k < 3; k++) begin
      step(); chk("t3_z_gap", z, 0);
    end
    send(1'b0); chk("t3_z_b4", z, 0);
    send(1'b1); chk("t3_z_b5", z, 0);
    send(1'b0); chk("t3_z_b6", z, 1);
    step();     chk("t3_z_one_cycle", z, 0);
    chk("t3_count", match_count, 1);

    // reset mid-operation clears history and restores default pattern
    abort = 1'b1; step(); abort = 1'b0;
    cfg_valid = 1'b1; cfg_pattern = 6'b110011; cfg_limit = 8'd0; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    send(1'b1); send(1'b0); send(1'b1); send(1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_count", match_count, 0);
    chk("t5_async_cfg_ready", cfg_ready, 1);
    step();
    rst = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    chk("t5_busy", busy, 1);
    s5 = 10'b1010101010;
    for (int k = 0; k < 6; k++) begin
      send(s5[9-k]);
      chk("t5_z", z, (k == 5) ? 1 : 0);
    end
    chk("t5_count", match_count, 1);

    // idle-gap behaviour
    abort = 1'b1; step(); abort = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    send(1'b1);
`ifdef SEQ_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      step();
      chk("t6_busy_wait", busy, 1);
      chk("t6_tmo_wait", timeout, 0);
    end
    step();
    chk("t6_busy_after", busy, 0);
    chk("t6_tmo_pulse", timeout, 1);
    step();
    chk("t6_tmo_clear", timeout, 0);
    chk("t6_count_held", match_count, 0);
`else
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t6_busy_stays", busy, 1);
      chk("t6_tmo_zero", timeout, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
